// File: rtl/pulse_meas.sv
// pulse_meas: measures the width of a high or low pulse, in clk_i cycles,
// from the one-cycle edge strobes of an upstream edge detector, and hands the
// result to a consumer over a valid/ready handshake.
//
// Optional feature macro: PULSE_MEAS_GLITCH_EN
//   When defined, pulses shorter than MIN_WIDTH cycles are discarded and
//   reported on filt_o. When undefined, filt_o is tied low and every
//   completed pulse produces a result.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   en_i     measurement enable
//   pol_i    1 = measure high pulse (re_i..fe_i), 0 = low pulse (fe_i..re_i)
//   re_i     rising-edge strobe
//   fe_i     falling-edge strobe
//   wid_o    measured width, CNT_WIDTH bits
//   ovf_o    width saturated (qualified by valid_o)
//   valid_o  result available
//   ready_i  consumer accepts the result
//   busy_o   measurement in progress
//   drop_o   one-cycle pulse: start edge ignored while a result is pending
//   filt_o   one-cycle pulse: pulse discarded as a glitch
module pulse_meas #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MIN_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 pol_i,
  input  logic                 re_i,
  input  logic                 fe_i,
  output logic [CNT_WIDTH-1:0] wid_o,
  output logic                 ovf_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 drop_o,
  output logic                 filt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 pol_q, pol_d;
  logic [CNT_WIDTH-1:0] wid_q, wid_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;
  logic                 filt_q, filt_d;

  // Simultaneous strobes are contradictory, so both are discarded.
  logic re_v_c, fe_v_c, start_c, end_c;
  assign re_v_c  = re_i & ~fe_i;
  assign fe_v_c  = fe_i & ~re_i;
  // Start follows the live polarity; end follows the polarity latched at start.
  assign start_c = en_i & (pol_i ? re_v_c : fe_v_c);
  assign end_c   = pol_q ? fe_v_c : re_v_c;

`ifndef PULSE_MEAS_GLITCH_EN
  // MIN_WIDTH only matters when glitch filtering is built in.
  if (MIN_WIDTH > 0) begin : g_min_width_unused
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      pol_q   <= 1'b0;
      wid_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      pol_q   <= pol_d;
      wid_q   <= wid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      filt_q  <= filt_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    pol_d   = pol_q;
    wid_d   = wid_q;
    ovf_d   = ovf_q;
    drop_d  = 1'b0;
    filt_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = S_MEAS;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
          pol_d   = pol_i;
        end
      end
      S_MEAS: begin
        if (!en_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (end_c) begin
          cnt_d = '0;
          sat_d = 1'b0;
`ifdef PULSE_MEAS_GLITCH_EN
          if (cnt_q < CNT_WIDTH'(MIN_WIDTH)) begin
            state_d = S_IDLE;
            filt_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            wid_d   = cnt_q;
            ovf_d   = sat_q;
          end
`else
          state_d = S_HOLD;
          wid_d   = cnt_q;
          ovf_d   = sat_q;
`endif
        end else if (cnt_q == CNT_MAX) begin
          // Counter pinned at full scale; remember that it overflowed.
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (ready_i) begin
          // Consume and, if a start edge coincides, begin the next pulse.
          if (start_c) begin
            state_d = S_MEAS;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
            pol_d   = pol_i;
          end else begin
            state_d = S_IDLE;
          end
        end else if (start_c) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // Outputs, all taken from registers.
  always_comb begin
    busy_o  = (state_q == S_MEAS);
    valid_o = (state_q == S_HOLD);
    wid_o   = wid_q;
    ovf_o   = ovf_q;
    drop_o  = drop_q;
`ifdef PULSE_MEAS_GLITCH_EN
    filt_o  = filt_q;
`else
    filt_o  = 1'b0;
`endif
  end

`ifndef PULSE_MEAS_GLITCH_EN
  // Glitch register has no consumer in this build.
  logic unused_filt_c;
  assign unused_filt_c = filt_q;
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Bench for pulse_meas: a 16-bit and a 4-bit instance share identical
// stimulus; expected results are queued per instance and popped by monitors
// on every valid/ready handshake.
module tb_pulse_meas;

  typedef struct packed {
    logic [15:0] wid;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i, en_i, pol_i, re_i, fe_i, ready_i;

  logic [15:0] wid16;
  logic        ovf16, valid16, busy16, drop16, filt16;
  logic [3:0]  wid4;
  logic        ovf4, valid4, busy4, drop4, filt4;

  exp_t q16[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pulse_meas #(.CNT_WIDTH(16), .MIN_WIDTH(3)) u16 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pol_i(pol_i), .re_i(re_i),
    .fe_i(fe_i), .wid_o(wid16), .ovf_o(ovf16), .valid_o(valid16),
    .ready_i(ready_i), .busy_o(busy16), .drop_o(drop16), .filt_o(filt16)
  );

  pulse_meas #(.CNT_WIDTH(4), .MIN_WIDTH(3)) u4 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pol_i(pol_i), .re_i(re_i),
    .fe_i(fe_i), .wid_o(wid4), .ovf_o(ovf4), .valid_o(valid4),
    .ready_i(ready_i), .busy_o(busy4), .drop_o(drop4), .filt_o(filt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived expectation: the 4-bit instance pins at 15 and flags
  // overflow once the pulse outlasts 15 cycles.
  task automatic expect_pulse(input int n, input int w4, input bit o4);
    exp_t e;
    e.wid = 16'(n);
    e.ovf = 1'b0;
    q16.push_back(e);
    e.wid = 16'(w4);
    e.ovf = o4;
    q4.push_back(e);
  endtask

  // Start strobe in cycle t, end strobe in cycle t+n.
  task automatic pulse(input int n, input bit pol, input bit flip);
    pol_i = pol;
    if (pol) re_i = 1'b1; else fe_i = 1'b1;
    step();
    re_i = 1'b0;
    fe_i = 1'b0;
    check("busy_in_meas", 32'(busy16), 1);
    if (flip) pol_i = ~pol;
    repeat (n - 1) step();
    if (pol) fe_i = 1'b1; else re_i = 1'b1;
    step();
    re_i = 1'b0;
    fe_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && (q16.size() != 0 || q4.size() != 0); i++) step();
    check({name, "_drained"}, 32'(q16.size() + q4.size()), 0);
    check({name, "_idle_busy"}, 32'(busy16 | busy4), 0);
    check({name, "_idle_valid"}, 32'(valid16 | valid4), 0);
  endtask

  // Scoreboard monitors: compare on each accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (valid16 === 1'b1 && ready_i === 1'b1) begin
      if (q16.size() == 0) begin
        check("unexpected_result16", 32'(wid16), 32'hFFFF_FFFF);
      end else begin
        e = q16.pop_front();
        check("wid16", 32'(wid16), 32'(e.wid));
        check("ovf16", 32'(ovf16), 32'(e.ovf));
      end
    end
    if (valid4 === 1'b1 && ready_i === 1'b1) begin
      if (q4.size() == 0) begin
        check("unexpected_result4", 32'(wid4), 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        check("wid4", 32'(wid4), 32'(e.wid));
        check("ovf4", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b1; pol_i = 1'b1; re_i = 1'b0; fe_i = 1'b0; ready_i = 1'b1;
    repeat (3) step();
    check("rst_wid16", 32'(wid16), 0);
    check("rst_ovf16", 32'(ovf16), 0);
    check("rst_valid16", 32'(valid16), 0);
    check("rst_busy16", 32'(busy16), 0);
    check("rst_drop16", 32'(drop16), 0);
    check("rst_filt16", 32'(filt16), 0);
    check("rst_wid4", 32'(wid4), 0);
    check("rst_valid4", 32'(valid4), 0);
    rst_i = 1'b0;
    repeat (6) step();

    // High pulse of 5 cycles, consumed immediately, back to idle next cycle.
    expect_pulse(5, 5, 1'b0);
    pulse(5, 1'b1, 1'b0);
    check("p5_valid", 32'(valid16), 1);
    check("p5_wid_direct", 32'(wid16), 5);
    step();
    check("p5_idle_valid", 32'(valid16), 0);
    check("p5_idle_busy", 32'(busy16), 0);
    wait_drain("p5");

    // 40-cycle pulse: exact on 16 bits, saturated on 4 bits.
    expect_pulse(40, 15, 1'b1);
    pulse(40, 1'b1, 1'b0);
    wait_drain("p40");

    // Low pulse of 7; pol_i flips mid-measurement and must be ignored.
    expect_pulse(7, 7, 1'b0);
    pulse(7, 1'b0, 1'b1);
    wait_drain("low7");
    pol_i = 1'b1;

    // Simultaneous strobes are ignored in IDLE and in MEAS.
    re_i = 1'b1; fe_i = 1'b1;
    step();
    re_i = 1'b0; fe_i = 1'b0;
    check("both_idle_busy", 32'(busy16), 0);
    expect_pulse(4, 4, 1'b0);
    re_i = 1'b1;
    step();
    fe_i = 1'b1;
    step();
    re_i = 1'b0; fe_i = 1'b0;
    check("both_meas_busy", 32'(busy16), 1);
    repeat (2) step();
    fe_i = 1'b1;
    step();
    fe_i = 1'b0;
    wait_drain("both");

    // Start edge while a result is pending: drop_o once, result held.
    ready_i = 1'b0;
    expect_pulse(4, 4, 1'b0);
    pulse(4, 1'b1, 1'b0);
    repeat (2) step();
    re_i = 1'b1;
    step();
    re_i = 1'b0;
    check("drop16_pulse", 32'(drop16), 1);
    check("drop4_pulse", 32'(drop4), 1);
    check("drop_hold_valid", 32'(valid16), 1);
    check("drop_hold_wid", 32'(wid16), 4);
    step();
    check("drop16_clear", 32'(drop16), 0);
    check("drop_hold_wid2", 32'(wid16), 4);
    ready_i = 1'b1;
    wait_drain("drop");

    // Accept in the same cycle as a new start: no drop, second width next.
    ready_i = 1'b0;
    expect_pulse(3, 3, 1'b0);
    pulse(3, 1'b1, 1'b0);
    step();
    ready_i = 1'b1;
    re_i = 1'b1;
    expect_pulse(6, 6, 1'b0);
    step();
    re_i = 1'b0;
    check("b2b_busy", 32'(busy16), 1);
    check("b2b_valid", 32'(valid16), 0);
    check("b2b_drop", 32'(drop16), 0);
    repeat (5) step();
    fe_i = 1'b1;
    step();
    fe_i = 1'b0;
    wait_drain("b2b");

    // Enable dropped mid-measurement: abort, last result retained.
    re_i = 1'b1;
    step();
    re_i = 1'b0;
    repeat (3) step();
    en_i = 1'b0;
    step();
    check("abort_busy", 32'(busy16), 0);
    check("abort_valid", 32'(valid16), 0);
    check("abort_wid_kept", 32'(wid16), 6);
    fe_i = 1'b1;
    step();
    fe_i = 1'b0;
    check("abort_no_result", 32'(valid16), 0);
    en_i = 1'b1;
    step();

    // Reset mid-measurement and mid-hold.
    re_i = 1'b1;
    step();
    re_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rstm_busy", 32'(busy16), 0);
    check("rstm_valid", 32'(valid16), 0);
    check("rstm_wid16", 32'(wid16), 0);
    check("rstm_wid4", 32'(wid4), 0);
    fe_i = 1'b1;
    step();
    fe_i = 1'b0;
    check("rstm_no_result", 32'(valid16), 0);
    ready_i = 1'b0;
    pulse(3, 1'b1, 1'b0);
    check("rsth_pending", 32'(valid16), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rsth_valid", 32'(valid16), 0);
    check("rsth_wid", 32'(wid16), 0);
    ready_i = 1'b1;
    step();

    // Two-cycle pulse: filtered with the glitch option, measured without.
`ifdef PULSE_MEAS_GLITCH_EN
    pulse(2, 1'b1, 1'b0);
    check("glitch_filt", 32'(filt16), 1);
    check("glitch_valid", 32'(valid16), 0);
    step();
    check("glitch_filt_clear", 32'(filt16), 0);
    check("glitch_idle", 32'(busy16 | valid16), 0);
`else
    expect_pulse(2, 2, 1'b0);
    pulse(2, 1'b1, 1'b0);
    check("short_valid", 32'(valid16), 1);
    check("short_filt", 32'(filt16), 0);
    wait_drain("short");
`endif
    expect_pulse(3, 3, 1'b0);
    pulse(3, 1'b1, 1'b0);
    wait_drain("min3");

    check("final_queue16", 32'(q16.size()), 0);
    check("final_queue4", 32'(q4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
